pc_branch_ctrl: RTL
===================

PC_BRANCH_CTRL -- requirements
Module: pc_branch_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2: number of flush cycles after a taken redirect; legal range 1..7.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 br_req  input  1  branch request; requester holds it high until br_ack.
REQ-005 br_offset  input  8  branch offset, sampled with br_req.
REQ-006 br_cond_ok  input  1  branch condition true; sampled with br_req.
REQ-007 stall  input  1  pipeline stall; blocks PC updates.
REQ-008 pc_in  input  8  current PC value from the PC datapath.
REQ-009 pc_select  output  1  PC mux select: 0 = PC+4, 1 = PC+offset.
REQ-010 pc_offset  output  8  offset driven to the PC offset adder.
REQ-011 pc_en  output  1  PC register load enable.
REQ-012 br_ack  output  1  one-cycle acceptance pulse for br_req.
REQ-013 flush  output  1  squash signal to fetch stage.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 taken_cnt  output  8  saturating count of committed taken branches.
REQ-016 carry_err  output  1  sticky flag: a committed redirect wrapped past 8'hFF.

Function
REQ-017 FSM states SHALL be IDLE, EVAL, REDIRECT, FLUSH.
REQ-018 IDLE: pc_select=0, pc_offset=0, pc_en = ~stall (combinational), flush=0, busy=0.
REQ-019 IDLE with br_req=1 and stall=0: latch br_offset and br_cond_ok, assert br_ack for that cycle, and go to EVAL next edge; in that cycle pc_en=0.
REQ-020 IDLE with br_req=1 and stall=1: no ack, no latch, remain IDLE.
REQ-021 EVAL: pc_en=0 for one cycle; latched cond=1 goes to REDIRECT, else IDLE.
REQ-022 REDIRECT: pc_select=1, pc_offset=latched offset, pc_en = ~stall; stall=1 holds REDIRECT; stall=0 commits: go to FLUSH, taken_cnt+1 saturating at 255.
REQ-023 On commit, carry_err SHALL set if pc_in + latched offset > 255 (9-bit sum); the PC wraps mod 256 regardless.
REQ-024 FLUSH: flush=1, pc_en=0 for exactly FLUSH_CYCLES cycles regardless of stall, via 3-bit down-counter; then IDLE.
REQ-025 br_req outside IDLE SHALL be ignored (no ack, no latch); held requests are accepted on return to IDLE.
REQ-026 br_ack SHALL never be high for two consecutive cycles.
REQ-027 Branch latency: not-taken = 2 cycles IDLE-to-IDLE; taken without stall = 3 + FLUSH_CYCLES cycles.

Reset
REQ-028 reset=1 SHALL force, asynchronously, state IDLE, latched offset/cond=0, flush counter=0, taken_cnt=0, carry_err=0.
REQ-029 While reset=1: pc_en=0, pc_select=0, pc_offset=0, br_ack=0, flush=0, busy=0.
REQ-030 Reset asserted mid-REDIRECT or mid-FLUSH SHALL abort without commit or taken_cnt increment; after release, state is IDLE.

Verification
REQ-031 Reset release, stall=0, no br_req -> pc_en=1 every cycle, pc_select=0, taken_cnt=0.
REQ-032 br_req=1, cond=1, offset=8'h10, pc_in=8'h20 -> ack cycle 0, EVAL cycle 1, REDIRECT cycle 2 (select=1, offset=8'h10, pc_en=1), flush=1 cycles 3-4, IDLE cycle 5, taken_cnt=1, carry_err=0.
REQ-033 br_req=1, cond=0 -> ack, EVAL, IDLE; no redirect, flush never asserted, taken_cnt unchanged.
REQ-034 Taken branch, stall=1 for 3 cycles in REDIRECT -> pc_en=0 while stalled, commit on first stall=0 cycle, flush still lasts exactly 2 cycles.
REQ-035 pc_in=8'hF8, offset=8'h10, taken -> carry_err=1 after commit, stays 1 through later branches until reset.
REQ-036 256 taken branches then reset mid-FLUSH -> taken_cnt=255 saturated before reset, all outputs 0 during reset, IDLE after release.

Source files
------------

// File: rtl/pc_branch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_branch_ctrl
//
// Branch control for a simple PC datapath. The block accepts a branch request,
// spends one cycle evaluating the latched condition, and for a taken branch
// steers the PC mux to PC+offset. Once that redirect commits, it squashes the
// fetch stage for FLUSH_CYCLES cycles. It also keeps a saturating count of
// committed taken branches, plus a sticky flag for redirects whose 9-bit
// target sum overflowed.
//
// Parameters
//   FLUSH_CYCLES : flush length after a committed redirect. Legal range 1..7,
//                  so the value fits the 3-bit flush down-counter.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   br_req     in   branch request, held by the requester until br_ack
//   br_offset  in   branch offset, sampled together with br_req
//   br_cond_ok in   branch condition, sampled together with br_req
//   stall      in   pipeline stall, blocks PC updates
//   pc_in      in   current PC value (used for the overflow check at commit)
//   pc_select  out  PC mux select: 0 = PC+4, 1 = PC+offset
//   pc_offset  out  offset presented to the PC offset adder
//   pc_en      out  PC register load enable
//   br_ack     out  one-cycle acceptance pulse for br_req
//   flush      out  squash to fetch stage
//   busy       out  high whenever the controller is not idle
//   taken_cnt  out  saturating count of committed taken branches
//   carry_err  out  sticky: a committed redirect wrapped past 8'hFF
// -----------------------------------------------------------------------------
module pc_branch_ctrl #(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       br_req,
   input  logic [7:0] br_offset,
   input  logic       br_cond_ok,
   input  logic       stall,
   input  logic [7:0] pc_in,
   output logic       pc_select,
   output logic [7:0] pc_offset,
   output logic       pc_en,
   output logic       br_ack,
   output logic       flush,
   output logic       busy,
   output logic [7:0] taken_cnt,
   output logic       carry_err
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_EVAL     = 2'd1,
      ST_REDIRECT = 2'd2,
      ST_FLUSH    = 2'd3
   } state_t;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
   localparam logic [7:0] CNT_MAX    = 8'hFF;

   state_t     state_q, state_d;
   logic [7:0] offset_q, offset_d;
   logic       cond_q, cond_d;
   logic [2:0] flush_cnt_q, flush_cnt_d;
   logic [7:0] taken_cnt_q, taken_cnt_d;
   logic       carry_err_q, carry_err_d;

   // 9-bit target sum. Bit 8 means the redirect wrapped past 8'hFF. The PC
   // datapath itself wraps mod 256. This block only records the event.
   logic [8:0] target_sum;

   assign target_sum = {1'b0, pc_in} + {1'b0, offset_q};

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         offset_q    <= 8'h00;
         cond_q      <= 1'b0;
         flush_cnt_q <= 3'd0;
         taken_cnt_q <= 8'h00;
         carry_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         offset_q    <= offset_d;
         cond_q      <= cond_d;
         flush_cnt_q <= flush_cnt_d;
         taken_cnt_q <= taken_cnt_d;
         carry_err_q <= carry_err_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state and output logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      offset_d    = offset_q;
      cond_d      = cond_q;
      flush_cnt_d = flush_cnt_q;
      taken_cnt_d = taken_cnt_q;
      carry_err_d = carry_err_q;

      pc_select   = 1'b0;
      pc_offset   = 8'h00;
      pc_en       = 1'b0;
      br_ack      = 1'b0;
      flush       = 1'b0;
      busy        = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            pc_en = ~stall;
            // Requests arriving during a stall are not lost. The requester
            // keeps br_req high, so the request is taken on a later cycle.
            if (br_req && !stall) begin
               br_ack   = 1'b1;
               pc_en    = 1'b0;
               offset_d = br_offset;
               cond_d   = br_cond_ok;
               state_d  = ST_EVAL;
            end
         end

         ST_EVAL: begin
            busy    = 1'b1;
            state_d = cond_q ? ST_REDIRECT : ST_IDLE;
         end

         ST_REDIRECT: begin
            busy      = 1'b1;
            pc_select = 1'b1;
            pc_offset = offset_q;
            pc_en     = ~stall;
            // The redirect commits on the first unstalled cycle. The PC loads
            // the new target on that same edge.
            if (!stall) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = FLUSH_LOAD;
               if (taken_cnt_q != CNT_MAX) begin
                  taken_cnt_d = taken_cnt_q + 8'd1;
               end
               if (target_sum[8]) begin
                  carry_err_d = 1'b1;
               end
            end
         end

         ST_FLUSH: begin
            busy  = 1'b1;
            flush = 1'b1;
            // Stall is deliberately ignored here. The squash window has a
            // fixed length, so the counter steps down every cycle.
            if (flush_cnt_q <= 3'd1) begin
               flush_cnt_d = 3'd0;
               state_d     = ST_IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q - 3'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // The state register already holds IDLE during reset. IDLE outputs still
      // depend on stall and br_req, so they are forced low here.
      if (reset) begin
         pc_select = 1'b0;
         pc_offset = 8'h00;
         pc_en     = 1'b0;
         br_ack    = 1'b0;
         flush     = 1'b0;
         busy      = 1'b0;
      end
   end

   assign taken_cnt = taken_cnt_q;
   assign carry_err = carry_err_q;

endmodule
